image_stream_ctrl: RTL and testbench

Frame sequencer that sits in front of the BMP writer. It accepts RGB pixel pairs from an upstream source over a valid/ready handshake and re-times them into the writer's one-cycle `hsync` strobe format. It inserts horizontal blanking between lines and vertical blanking after the last line. It tracks column/row position and reports frame start/done, so the writer and the testbench see a well-formed frame of WIDTH x HEIGHT pixels.

---
 rtl/image_pkg.sv | 29 ++
 rtl/image_blank_timer.sv | 33 +++
 rtl/image_stream_ctrl.sv | 161 ++++++++++++++++
 tb/tb_image_stream_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// Shared types and constants for the image stream sequencer and its blanking timer.
package image_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_HBLANK,
    ST_VBLANK,
    ST_DONE
  } state_t;

  // Pixel pair packing: {R0,G0,B0,R1,G1,B1}, R0 in the MSBs.
  localparam int PAIR_W = 48;
  localparam int R0_LSB = 40;
  localparam int G0_LSB = 32;
  localparam int B0_LSB = 24;
  localparam int R1_LSB = 16;
  localparam int G1_LSB = 8;
  localparam int B1_LSB = 0;

  localparam int DEF_WIDTH  = 768;
  localparam int DEF_HEIGHT = 512;
  localparam int DEF_HBLANK = 160;
  localparam int DEF_VBLANK = 1000;

  localparam int POS_W   = 16;
  localparam int TIMER_W = 32;

endpackage

// File: rtl/image_blank_timer.sv
// Loadable down-counter with a zero flag; times both horizontal and vertical blanking.
module image_blank_timer
  import image_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/image_stream_ctrl.sv
// Frame sequencer: re-times upstream pixel pairs into one-cycle hsync strobes with line/frame blanking.
// Optional stall counter built only when IMAGE_STREAM_STALL_CNT_EN is defined.
module image_stream_ctrl
  import image_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int HBLANK = DEF_HBLANK,
  parameter int VBLANK = DEF_VBLANK
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              start,
  input  logic              abort,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic [PAIR_W-1:0] src_data,
  output logic              hsync,
  output logic [PAIR_W-1:0] out_data,
  output logic [POS_W-1:0]  col,
  output logic [POS_W-1:0]  row,
  output logic              frame_start,
  output logic              frame_done,
  output logic              busy,
  output logic [31:0]       stall_cycles
);

  localparam logic [POS_W-1:0]   LAST_COL = POS_W'(WIDTH / 2 - 1);
  localparam logic [POS_W-1:0]   LAST_ROW = POS_W'(HEIGHT - 1);
  localparam logic [TIMER_W-1:0] HB_LOAD  = TIMER_W'(HBLANK - 1);
  localparam logic [TIMER_W-1:0] VB_LOAD  = TIMER_W'(VBLANK - 1);

  state_t             state;
  logic [POS_W-1:0]   col_cnt;
  logic [POS_W-1:0]   row_cnt;
  logic               xfer;
  logic               line_end;
  logic               tmr_load;
  logic               tmr_dec;
  logic               tmr_zero;
  logic [TIMER_W-1:0] tmr_value;

  assign src_ready = (state == ST_ACTIVE);
  assign xfer      = src_valid && src_ready;
  assign line_end  = xfer && (col_cnt == LAST_COL);

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    tmr_value = (row_cnt == LAST_ROW) ? VB_LOAD : HB_LOAD;
    if (!abort) begin
      tmr_load = line_end;
      tmr_dec  = (state == ST_HBLANK || state == ST_VBLANK) && !tmr_zero;
    end
  end

  image_blank_timer #(.W(TIMER_W)) u_timer (
    .clk        (HCLK),
    .rst_n      (HRESETn),
    .clear      (abort),
    .load       (tmr_load),
    .load_value (tmr_value),
    .dec        (tmr_dec),
    .zero       (tmr_zero)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= ST_IDLE;
      col_cnt     <= '0;
      row_cnt     <= '0;
      hsync       <= 1'b0;
      out_data    <= '0;
      col         <= '0;
      row         <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      hsync       <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      if (abort) begin
        // A transfer coinciding with abort is dropped: no strobe, no output update.
        state   <= ST_IDLE;
        col_cnt <= '0;
        row_cnt <= '0;
        busy    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state       <= ST_ACTIVE;
              frame_start <= 1'b1;
              busy        <= 1'b1;
              col_cnt     <= '0;
              row_cnt     <= '0;
            end
          end
          ST_ACTIVE: begin
            if (xfer) begin
              out_data <= src_data;
              col      <= col_cnt;
              row      <= row_cnt;
              hsync    <= 1'b1;
              if (line_end) begin
                col_cnt <= '0;
                if (row_cnt == LAST_ROW) begin
                  state <= ST_VBLANK;
                end else begin
                  state   <= ST_HBLANK;
                  row_cnt <= row_cnt + POS_W'(1);
                end
              end else begin
                col_cnt <= col_cnt + POS_W'(1);
              end
            end
          end
          ST_HBLANK: begin
            if (tmr_zero) state <= ST_ACTIVE;
          end
          ST_VBLANK: begin
            if (tmr_zero) begin
              state      <= ST_DONE;
              frame_done <= 1'b1;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef IMAGE_STREAM_STALL_CNT_EN
  logic [31:0] stall_cnt;

  // Cleared on the IDLE->ACTIVE edge so the first ACTIVE cycle already counts; held otherwise.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      stall_cnt <= '0;
    end else if (state == ST_IDLE && start && !abort) begin
      stall_cnt <= '0;
    end else if (state == ST_ACTIVE && !src_valid && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_image_stream_ctrl.sv
// Self-checking bench for image_stream_ctrl (WIDTH=8, HEIGHT=4, HBLANK=2, VBLANK=3) against a frame-level model.
module tb_image_stream_ctrl;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int HB    = 2;
  localparam int VB    = 3;
  localparam int PAIRS = W / 2;
  localparam int TOTAL = W * H / 2;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        src_valid;
  logic        src_ready;
  logic [47:0] src_data;
  logic        hsync;
  logic [47:0] out_data;
  logic [15:0] col;
  logic [15:0] row;
  logic        frame_start;
  logic        frame_done;
  logic        busy;
  logic [31:0] stall_cycles;

  image_stream_ctrl #(.WIDTH(W), .HEIGHT(H), .HBLANK(HB), .VBLANK(VB)) dut (
    .HCLK         (clk),
    .HRESETn      (rst_n),
    .start        (start),
    .abort        (abort),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .src_data     (src_data),
    .hsync        (hsync),
    .out_data     (out_data),
    .col          (col),
    .row          (row),
    .frame_start  (frame_start),
    .frame_done   (frame_done),
    .busy         (busy),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level model: pairs accepted so far, idle cycles left in the current gap, done cycle.
  bit          m_on;
  bit          m_fin;
  int          m_k;
  int          m_gap;
  bit          e_hsync;
  bit          e_fs;
  bit          e_fd;
  logic [47:0] e_data;
  int          e_col;
  int          e_row;
  logic [31:0] e_stall;

  int cyc;
  int strobes_seen;
  int fs_seen;
  int fd_seen;
  int last_fs;
  int last_fd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_accepting();
    return m_on && !m_fin && (m_gap == 0);
  endfunction

  task automatic model_reset();
    m_on = 0; m_fin = 0; m_k = 0; m_gap = 0;
    e_hsync = 0; e_fs = 0; e_fd = 0;
    e_data = '0; e_col = 0; e_row = 0; e_stall = '0;
  endtask

  task automatic model_step(input bit st, input bit ab, input bit vl, input logic [47:0] d);
    e_hsync = 0; e_fs = 0; e_fd = 0;
    if (ab) begin
      m_on = 0; m_fin = 0; m_k = 0; m_gap = 0;
    end else if (!m_on) begin
      if (st) begin
        m_on = 1; m_k = 0; m_gap = 0; e_fs = 1; e_stall = '0;
      end
    end else if (m_fin) begin
      m_on = 0; m_fin = 0;
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0 && m_k == TOTAL) begin
        m_fin = 1; e_fd = 1;
      end
    end else if (!vl) begin
      if (e_stall != 32'hFFFF_FFFF) e_stall++;
    end else begin
      e_hsync = 1;
      e_data  = d;
      e_row   = m_k / PAIRS;
      e_col   = m_k % PAIRS;
      m_k++;
      if (m_k % PAIRS == 0) m_gap = (m_k == TOTAL) ? VB : HB;
    end
  endtask

  task automatic compare_all();
    check("hsync", hsync, e_hsync);
    check("frame_start", frame_start, e_fs);
    check("frame_done", frame_done, e_fd);
    check("busy", busy, m_on);
    check("src_ready", src_ready, m_accepting());
    check("out_data", out_data, e_data);
    check("col", col, 64'(e_col));
    check("row", row, 64'(e_row));
`ifdef IMAGE_STREAM_STALL_CNT_EN
    check("stall_cycles", stall_cycles, e_stall);
`else
    check("stall_cycles", stall_cycles, 0);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_src_ready"}, src_ready, 0);
    check({tag, "_hsync"}, hsync, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_col"}, col, 0);
    check({tag, "_row"}, row, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_stall"}, stall_cycles, 0);
  endtask

  task automatic clear_obs();
    strobes_seen = 0; fs_seen = 0; fd_seen = 0; last_fs = -1; last_fd = -1;
  endtask

  task automatic tick(input bit st, input bit ab, input bit vl, input logic [47:0] d);
    start = st; abort = ab; src_valid = vl; src_data = d;
    @(posedge clk);
    model_step(st, ab, vl, d);
    #1;
    cyc++;
    if (hsync) strobes_seen++;
    if (frame_start) begin fs_seen++; last_fs = cyc; end
    if (frame_done)  begin fd_seen++; last_fd = cyc; end
    compare_all();
  endtask

  // vmode 0: valid always; 1: valid low on the first ACTIVE cycle then alternating; 2: random.
  task automatic run_frame(input int vmode, input int abort_at);
    int          rel;
    bit          v;
    bit          ab;
    logic [47:0] d;
    clear_obs();
    tick(1'b1, 1'b0, 1'b0, '0);
    rel = 0;
    while (m_on && rel < 400) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = rel[0];
        default: v = 1'($urandom_range(0, 1));
      endcase
      d  = (vmode == 2) ? {16'($urandom), 32'($urandom)} : 48'(m_k);
      ab = (abort_at >= 0) && m_accepting() && v && (m_k == abort_at);
      tick(1'b0, ab, v, d);
      rel++;
    end
    check("frame_timeout", {63'd0, m_on}, 0);
  endtask

  initial begin
    cyc = 0;
    clear_obs();
    model_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; src_valid = 1'b0; src_data = '0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 1'b1, 48'h1234);

    // Continuous valid: 16 strobes, frame_done 25 cycles after the first ACTIVE cycle.
    run_frame(0, -1);
    check("cont_strobes", strobes_seen, TOTAL);
    check("cont_fd_count", fd_seen, 1);
    check("cont_fd_latency", last_fd - last_fs, 25);

    // Alternating valid starting low: 4 stalls per line.
    run_frame(1, -1);
    check("toggle_strobes", strobes_seen, TOTAL);
`ifdef IMAGE_STREAM_STALL_CNT_EN
    check("toggle_stall_total", stall_cycles, 16);
`else
    check("toggle_stall_total", stall_cycles, 0);
`endif
    tick(1'b0, 1'b0, 1'b0, '0);

    // Random valid and data.
    for (int f = 0; f < 2; f++) begin
      run_frame(2, -1);
      check("rand_strobes", strobes_seen, TOTAL);
      check("rand_fd_count", fd_seen, 1);
    end

    // Abort on the 6th transfer, then a full frame.
    run_frame(0, 5);
    check("abort_strobes", strobes_seen, 5);
    check("abort_no_done", fd_seen, 0);
    run_frame(0, -1);
    check("after_abort_strobes", strobes_seen, TOTAL);
    check("after_abort_fd", fd_seen, 1);

    // start held high: back-to-back frames, one IDLE cycle between DONE and ACTIVE.
    clear_obs();
    for (int i = 0; i < 200 && fd_seen < 2; i++) tick(1'b1, 1'b0, 1'b1, 48'(m_k));
    check("hold_fd_count", fd_seen, 2);
    check("hold_fs_count", fs_seen, 2);
    check("hold_strobes", strobes_seen, 2 * TOTAL);
    tick(1'b1, 1'b0, 1'b1, '0);
    tick(1'b1, 1'b0, 1'b1, '0);
    check("hold_restart_gap", last_fs - last_fd, 2);
    tick(1'b0, 1'b1, 1'b0, '0);

    // Reset asserted in the middle of horizontal blanking.
    tick(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 100 && !(m_gap > 0 && m_k > 0 && m_k < TOTAL); i++)
      tick(1'b0, 1'b0, 1'b1, 48'hABC0 + 48'(m_k));
    check("pre_reset_busy", busy, 1);
    check("pre_reset_ready", src_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 1'b1, '0);
    check("post_reset_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
